// File: rtl/mmu_pkg.sv
// mmu_pkg: shared register map helpers, tag-register bit positions and scanner states for mmu_pager.
// Register map: tag windows at 0..NWIN-1, then FAULT, VICTIM and CTRL directly above them.
package mmu_pkg;
    localparam int TAG_DIRTY = 0;
    localparam int TAG_REF   = 1;
    localparam int TAG_VALID = 2;
    localparam int TAG_WP    = 3;
    typedef enum logic {S_IDLE, S_SCAN} scan_state_t;
    function automatic logic [3:0] reg_fault(input int nwin);
        return 4'(nwin);
    endfunction
    function automatic logic [3:0] reg_victim(input int nwin);
        return 4'(nwin + 1);
    endfunction
    function automatic logic [3:0] reg_ctrl(input int nwin);
        return 4'(nwin + 2);
    endfunction
endpackage

// File: rtl/mmu_victim_scan.sv
// mmu_victim_scan: clock-algorithm victim scanner (FSM, hand, busy/done).
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   i_start           begin a scan (ignored while a scan is running)
//   i_load/i_load_val load hand with i_load_val mod NWIN and clear done
//   i_valid, i_ref    per-window valid and referenced bits
//   o_ref_clr         one-hot ref clear for the window under the hand
//   o_hand            current hand position
//   o_busy, o_done    scan running / scan finished
module mmu_victim_scan
    import mmu_pkg::*;
#(
    parameter int NWIN  = 4,
    parameter int WIN_W = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             i_start,
    input  logic             i_load,
    input  logic [2:0]       i_load_val,
    input  logic [NWIN-1:0]  i_valid,
    input  logic [NWIN-1:0]  i_ref,
    output logic [NWIN-1:0]  o_ref_clr,
    output logic [WIN_W-1:0] o_hand,
    output logic             o_busy,
    output logic             o_done
);
    scan_state_t      r_state;
    logic [WIN_W-1:0] r_hand;
    logic             r_busy;
    logic             r_done;
    logic             w_take;
    logic [WIN_W-1:0] w_next;
    logic [WIN_W-1:0] w_load;

    // A referenced window gets a second chance: clear its ref and move on.
    assign w_take    = (r_state == S_SCAN) && i_valid[r_hand] && i_ref[r_hand];
    assign o_ref_clr = w_take ? (NWIN'(1) << r_hand) : '0;
    assign w_next    = (r_hand == WIN_W'(NWIN - 1)) ? '0 : r_hand + WIN_W'(1);
    assign w_load    = WIN_W'(32'(i_load_val) % NWIN);
    assign o_hand    = r_hand;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_hand  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_state <= S_SCAN;
                    r_busy  <= 1'b1;
                    r_done  <= 1'b0;
                end
                S_SCAN: if (w_take) begin
                    r_hand <= w_next;
                end else begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
            if (i_load) begin
                r_hand <= w_load;
                r_done <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/mmu_pager.sv
// mmu_pager: NWIN-window page mapper with hit decode, dirty/ref tracking, fault capture and victim scan.
// Optional write protection is enabled by defining MMU_WRITE_PROTECT_EN.
// Ports:
//   CLK, RESET   clock, synchronous active-high reset
//   ADDR         CPU address
//   DO           CPU write data (register writes)
//   RW           1 = read, 0 = write
//   ACC          bus access valid this cycle
//   BYPASS       access to fixed RAM / I/O: no lookup side effects, no fault
//   CS, AD       register file select and index
//   REG_D        register read data (combinational)
//   HIT          ADDR page matches a valid window
//   PHYS_ADDR    {window index, page offset}, zero on a miss
//   FAULT_INTR   level fault interrupt
module mmu_pager
    import mmu_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int PAGE_W = 5,
    parameter int NWIN   = 4,
    parameter int WIN_W  = (NWIN > 1) ? $clog2(NWIN) : 1
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic [ADDR_W-1:0]                ADDR,
    input  logic [7:0]                       DO,
    input  logic                             RW,
    input  logic                             ACC,
    input  logic                             BYPASS,
    input  logic                             CS,
    input  logic [3:0]                       AD,
    output logic [7:0]                       REG_D,
    output logic                             HIT,
    output logic [WIN_W+ADDR_W-PAGE_W-1:0]   PHYS_ADDR,
    output logic                             FAULT_INTR
);
    localparam int OFF_W = ADDR_W - PAGE_W;

    logic [PAGE_W-1:0] r_tag [NWIN];
    logic [NWIN-1:0]   r_valid;
    logic [NWIN-1:0]   r_ref;
    logic [NWIN-1:0]   r_dirty;
    logic              r_pend;
    logic              r_wpc;
    logic [4:0]        r_fpage;
    logic [7:0]        r_ctrl;
    logic [NWIN-1:0]   w_wp;
    logic [NWIN-1:0]   w_match;
    logic [NWIN-1:0]   w_ref_clr;
    logic [WIN_W-1:0]  w_win;
    logic [WIN_W-1:0]  w_hand;
    logic [PAGE_W-1:0] w_page;
    logic              w_acc;
    logic              w_wr;
    logic              w_wp_fault;
    logic              w_fault;
    logic              w_busy;
    logic              w_done;

`ifdef MMU_WRITE_PROTECT_EN
    logic [NWIN-1:0]   r_wp;
    assign w_wp = r_wp;
`else
    assign w_wp = '0;
`endif

    assign w_page     = ADDR[ADDR_W-1 -: PAGE_W];
    assign w_acc      = ACC & ~BYPASS & ~CS;
    assign w_wr       = CS & ~RW;
    assign w_wp_fault = w_acc & HIT & ~RW & w_wp[w_win];
    assign w_fault    = w_acc & (~HIT | w_wp_fault);
    assign FAULT_INTR = r_pend & r_ctrl[0];

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        w_match = '0;
        w_win   = '0;
        for (int i = 0; i < NWIN; i++) w_match[i] = r_valid[i] && (r_tag[i] == w_page);
        for (int i = NWIN - 1; i >= 0; i--) if (w_match[i]) w_win = WIN_W'(i);
    end

    assign HIT       = |w_match;
    assign PHYS_ADDR = HIT ? {w_win, ADDR[OFF_W-1:0]} : '0;

    // The hit-driven ref set is assigned after the scanner clear so it wins.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NWIN; i++) r_tag[i] <= PAGE_W'(i + 1);
            r_valid <= '1;
            r_ref   <= '0;
            r_dirty <= '0;
`ifdef MMU_WRITE_PROTECT_EN
            r_wp    <= '0;
`endif
        end else begin
            for (int i = 0; i < NWIN; i++) begin
                if (w_wr && AD == 4'(i)) begin
                    r_tag[i]   <= DO[7 -: PAGE_W];
                    r_valid[i] <= 1'b1;
                    r_dirty[i] <= 1'b0;
                    r_ref[i]   <= 1'b1;
`ifdef MMU_WRITE_PROTECT_EN
                    r_wp[i]    <= DO[TAG_WP];
`endif
                end else begin
                    if (w_ref_clr[i]) r_ref[i] <= 1'b0;
                    if (w_acc && HIT && w_win == WIN_W'(i)) begin
                        r_ref[i] <= 1'b1;
                        if (~RW && ~w_wp[i]) r_dirty[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Only the first fault is captured until software clears pending.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pend  <= 1'b0;
            r_wpc   <= 1'b0;
            r_fpage <= '0;
            r_ctrl  <= 8'h01;
        end else begin
            if (w_wr && AD == reg_fault(NWIN)) begin
                r_pend <= 1'b0;
            end else if (w_fault && ~r_pend) begin
                r_pend  <= 1'b1;
                r_fpage <= 5'(w_page);
                r_wpc   <= w_wp_fault;
            end
            if (w_wr && AD == reg_ctrl(NWIN)) r_ctrl <= DO;
        end
    end

    mmu_victim_scan #(.NWIN(NWIN), .WIN_W(WIN_W)) u_scan (
        .CLK        (CLK),
        .RESET      (RESET),
        .i_start    (w_wr && AD == reg_victim(NWIN) && DO[7]),
        .i_load     (w_wr && AD == reg_victim(NWIN) && ~DO[7]),
        .i_load_val (DO[2:0]),
        .i_valid    (r_valid),
        .i_ref      (r_ref),
        .o_ref_clr  (w_ref_clr),
        .o_hand     (w_hand),
        .o_busy     (w_busy),
        .o_done     (w_done)
    );

    always_comb begin
        REG_D = 8'h00;
        for (int i = 0; i < NWIN; i++) begin
            if (AD == 4'(i)) begin
                REG_D            = {r_tag[i], {(8-PAGE_W){1'b0}}};
                REG_D[TAG_WP]    = REG_D[TAG_WP] | w_wp[i];
                REG_D[TAG_VALID] = r_valid[i];
                REG_D[TAG_REF]   = r_ref[i];
                REG_D[TAG_DIRTY] = r_dirty[i];
            end
        end
        if (AD == reg_fault(NWIN))  REG_D = {r_fpage, r_wpc, 1'b0, r_pend};
        if (AD == reg_victim(NWIN)) REG_D = {w_busy, w_done, 3'b000, 3'(w_hand)};
        if (AD == reg_ctrl(NWIN))   REG_D = r_ctrl;
    end
endmodule
